// File: rtl/mem_line_server.sv
// Line-wide main-memory responder for icache fills and dcache reads/writebacks, fixed access latency.
// Optional round-robin arbitration between the two caches is enabled by defining MEM_ARB_RR_EN.
module mem_line_server #(
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LINES   = 1024,
    parameter int MEM_LATENCY = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ic_req,
    input  logic [31:0]                ic_addr,
    output logic                       ic_ready,
    output logic [32*LINE_WORDS-1:0]   ic_rdata,
    input  logic                       dc_req,
    input  logic                       dc_we,
    input  logic [31:0]                dc_addr,
    input  logic [32*LINE_WORDS-1:0]   dc_wdata,
    output logic                       dc_ready,
    output logic [32*LINE_WORDS-1:0]   dc_rdata,
    output logic                       mem_busy
);
    localparam int LW  = 32 * LINE_WORDS;
    localparam int OFS = $clog2(LINE_WORDS * 4);
    localparam int IDX = $clog2(MEM_LINES);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t          r_state;
    logic [7:0]      r_timer;
    logic            r_gnt_ic;
    logic            r_gnt_dc;
    logic            r_we;
    logic [IDX-1:0]  r_idx;
    logic [LW-1:0]   r_wdata;
    logic [LW-1:0]   r_mem [MEM_LINES];
    logic            r_ic_ready;
    logic            r_dc_ready;
    logic            r_busy;
    logic [LW-1:0]   r_ic_rdata;
    logic [LW-1:0]   r_dc_rdata;

    logic            w_any_req;
    logic            w_pick_dc;
    logic            w_grant;
    logic            w_write;
    logic [IDX-1:0]  w_ic_idx;
    logic [IDX-1:0]  w_dc_idx;
    logic [31:0]     w_unused_addr;

    // Offset bits and bits above the index are ignored, so addresses alias modulo the array size.
    assign w_ic_idx      = ic_addr[OFS +: IDX];
    assign w_dc_idx      = dc_addr[OFS +: IDX];
    assign w_unused_addr = ic_addr ^ dc_addr;

    assign w_any_req = ic_req | dc_req;
    assign w_grant   = (r_state == S_IDLE) && w_any_req;
    assign w_write   = (r_state == S_BUSY) && (r_timer == 8'd0) && r_we;

`ifdef MEM_ARB_RR_EN
    logic r_rr_ic;

    // r_rr_ic set means the icache wins the next tie; it flips to the other port on every grant.
    assign w_pick_dc = dc_req && !(ic_req && r_rr_ic);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_rr_ic <= 1'b1;
        else if (w_grant)
            r_rr_ic <= w_pick_dc;
    end
`else
    assign w_pick_dc = dc_req;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_timer    <= 8'd0;
            r_gnt_ic   <= 1'b0;
            r_gnt_dc   <= 1'b0;
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_ic_rdata <= '0;
            r_dc_rdata <= '0;
        end else begin
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_dc <= w_pick_dc;
                        r_gnt_ic <= !w_pick_dc;
                        r_timer  <= 8'(MEM_LATENCY - 1);
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_timer == 8'd0) begin
                        r_state <= S_RESP;
                        if (r_gnt_dc) begin
                            r_dc_ready <= 1'b1;
                            r_dc_rdata <= r_we ? r_wdata : r_mem[r_idx];
                        end else begin
                            r_ic_ready <= 1'b1;
                            r_ic_rdata <= r_mem[r_idx];
                        end
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_RESP: begin
                    r_busy   <= 1'b0;
                    r_gnt_ic <= 1'b0;
                    r_gnt_dc <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request payload is captured at grant; the array itself is never reset.
    always_ff @(posedge clock) begin
        if (w_grant) begin
            r_idx   <= w_pick_dc ? w_dc_idx : w_ic_idx;
            r_we    <= w_pick_dc & dc_we;
            r_wdata <= dc_wdata;
        end
        if (w_write)
            r_mem[r_idx] <= r_wdata;
    end

    assign ic_ready = r_ic_ready;
    assign ic_rdata = r_ic_rdata;
    assign dc_ready = r_dc_ready;
    assign dc_rdata = r_dc_rdata;
    assign mem_busy = r_busy;

endmodule
